sequenciador_servo: RTL and testbench
=====================================

// Module: sequenciador_servo
// PURPOSE
//   Sequencer that drives the 2-bit posicao input of controle_servo. On request it
//   sweeps the servo 00->01->10->11->10->01->00, holding each position for a fixed
//   dwell time, then either stops (single sweep) or keeps oscillating (continuous).
//   Sits between the top-level control and controle_servo; one instance per servo.
// PARAMETERS
//   DWELL   50_000_000  clock cycles each position is held (1 s @ 50 MHz); must be >= 2
//   CW      $clog2(DWELL)  dwell counter width (derived, not overridden)
// PORTS
//   clock       in   1   system clock, all logic on rising edge
//   reset       in   1   asynchronous, active-low reset (0 = reset)
//   iniciar     in   1   start request, sampled only in INICIAL
//   parar       in   1   abort request, sampled every cycle outside reset
//   continuo    in   1   1 = repeat sweeps forever, 0 = one sweep; sampled at each return to 00
//   posicao     out  2   position code to controle_servo
//   ocupado     out  1   1 while in POSICIONA
//   fim         out  1   one-cycle pulse when a single sweep completes
//   db_estado   out  4   FSM state code for debug displays
// BEHAVIOUR
//   Reset (reset=0, async): state=INICIAL, posicao=00, sentido=0 (up), contador=0,
//     ocupado=0, fim=0, db_estado=0000. Release is synchronised to clock.
//   States / db_estado: INICIAL=0000, POSICIONA=0001, FINAL=0010.
//   INICIAL: posicao=00, contador=0, sentido=0. iniciar=1 & parar=0 -> POSICIONA next
//     cycle; posicao=00 from that cycle. iniciar=1 & parar=1 -> stay INICIAL.
//   POSICIONA: ocupado=1. contador increments each cycle; posicao constant while
//     contador < DWELL-1. At contador==DWELL-1: contador<=0 and, on the same edge:
//       sentido=0, posicao<3  -> posicao+1
//       sentido=0, posicao==3 -> posicao=10, sentido=1
//       sentido=1, posicao>0  -> posicao-1
//       sentido=1, posicao==0 -> continuo=1: posicao=01, sentido=0 (no repeat dwell at 00)
//                                continuo=0: -> FINAL, posicao stays 00
//     Each position is therefore held exactly DWELL cycles; one sweep = 7*DWELL cycles.
//   FINAL: one cycle, fim=1, ocupado=0, posicao=00 -> INICIAL. iniciar ignored here.
//   parar=1 in POSICIONA (any contador value, incl. terminal count): next cycle
//     state=INICIAL, posicao=00, contador=0, sentido=0, no fim pulse. parar has
//     priority over terminal-count transition and over iniciar.
//   continuo may change mid-sweep; only its value at the 00 terminal count matters.
//   fim and ocupado are registered outputs, never high together.
//   contador never exceeds DWELL-1; no wrap-around of posicao beyond 00..11.
//   Reset asserted mid-sweep: immediate return to reset values (posicao=00).
// TESTING (sim with DWELL=4; cycle 0 = edge where iniciar=1 is sampled)
//   1 Reset: hold reset=0 with iniciar=1 -> posicao=00, ocupado=0, fim=0, db_estado=0000.
//   2 Single sweep, continuo=0, iniciar pulse -> posicao 00 cyc1-4, 01 5-8, 10 9-12,
//     11 13-16, 10 17-20, 01 21-24, 00 25-28; fim=1 only cyc29; ocupado=1 cyc1-28.
//   3 Continuous, continuo=1 -> after 00 dwell cyc25-28, posicao=01 cyc29-32, 10
//     cyc33-36; no fim; drop continuo=0 mid-sweep -> sweep ends at next 00, fim pulses once.
//   4 Abort: parar=1 at cyc14 (posicao=11) -> cyc15 posicao=00, INICIAL, ocupado=0,
//     fim never asserted; parar=1 exactly at a terminal count -> same result.
//   5 Simultaneous iniciar=1 & parar=1 in INICIAL -> stays INICIAL; iniciar held high
//     through FINAL -> new sweep starts cycle after return to INICIAL.
//   6 Async reset pulse at cyc10 between clock edges -> posicao=00, db_estado=0000
//     immediately, before next clock edge.

Source files
------------

// File: rtl/sequenciador_servo.sv
// sequenciador_servo: sweeps the 2-bit servo position 00->01->10->11->10->01->00.
// Each position is held for DWELL clock cycles. After the sweep the block either
// stops (single sweep) or keeps oscillating (continuous mode).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INICIAL   | idle, posicao=00, waits for iniciar (without parar)
// POSICIONA | sweeping, dwell counter running, ocupado=1
// FINAL     | single sweep finished, one-cycle fim pulse
module sequenciador_servo #(
    parameter int DWELL = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       continuo,
    output logic [1:0] posicao,
    output logic       ocupado,
    output logic       fim,
    output logic [3:0] db_estado
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CONT_TC = CW'(DWELL - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'b0000,
        POSICIONA = 4'b0001,
        FINAL     = 4'b0010
    } estado_t;

    logic          rst_meta_q;
    logic          rst_sync_q;

    estado_t       estado_q, estado_d;
    logic [1:0]    posicao_q, posicao_d;
    logic          sentido_q, sentido_d;
    logic [CW-1:0] contador_q, contador_d;
    logic          ocupado_q, ocupado_d;
    logic          fim_q, fim_d;

    // Reset asserts immediately, releases two clock edges later in sync with clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Next-state, position, direction and dwell counter; parar wins over everything.
    always_comb begin
        estado_d   = estado_q;
        posicao_d  = posicao_q;
        sentido_d  = sentido_q;
        contador_d = contador_q;
        case (estado_q)
            INICIAL: begin
                posicao_d  = 2'b00;
                sentido_d  = 1'b0;
                contador_d = '0;
                if (iniciar && !parar) begin
                    estado_d = POSICIONA;
                end
            end
            POSICIONA: begin
                if (parar) begin
                    estado_d   = INICIAL;
                    posicao_d  = 2'b00;
                    sentido_d  = 1'b0;
                    contador_d = '0;
                end else if (contador_q == CONT_TC) begin
                    contador_d = '0;
                    if (!sentido_q) begin
                        if (posicao_q != 2'b11) begin
                            posicao_d = posicao_q + 2'd1;
                        end else begin
                            posicao_d = 2'b10;
                            sentido_d = 1'b1;
                        end
                    end else if (posicao_q != 2'b00) begin
                        posicao_d = posicao_q - 2'd1;
                    end else if (continuo) begin
                        // restart upward without a second dwell at 00
                        posicao_d = 2'b01;
                        sentido_d = 1'b0;
                    end else begin
                        estado_d = FINAL;
                    end
                end else begin
                    contador_d = contador_q + 1'b1;
                end
            end
            FINAL: begin
                estado_d   = INICIAL;
                posicao_d  = 2'b00;
                sentido_d  = 1'b0;
                contador_d = '0;
            end
            default: begin
                estado_d   = INICIAL;
                posicao_d  = 2'b00;
                sentido_d  = 1'b0;
                contador_d = '0;
            end
        endcase
        ocupado_d = (estado_d == POSICIONA);
        fim_d     = (estado_d == FINAL);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            estado_q   <= INICIAL;
            posicao_q  <= 2'b00;
            sentido_q  <= 1'b0;
            contador_q <= '0;
            ocupado_q  <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            posicao_q  <= posicao_d;
            sentido_q  <= sentido_d;
            contador_q <= contador_d;
            ocupado_q  <= ocupado_d;
            fim_q      <= fim_d;
        end
    end

    assign posicao   = posicao_q;
    assign ocupado   = ocupado_q;
    assign fim       = fim_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_servo.sv
// Bench for sequenciador_servo with a short dwell time.
module tb_sequenciador_servo;

    localparam int DWELL = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       parar = 1'b0;
    logic       continuo = 1'b0;
    logic [1:0] posicao;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;

    sequenciador_servo #(.DWELL(DWELL)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .continuo  (continuo),
        .posicao   (posicao),
        .ocupado   (ocupado),
        .fim       (fim),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ini;
        logic       par;
        logic       con;
        int         n;
        logic [1:0] pos;
        logic       oc;
        logic       fm;
        logic [3:0] db;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic i, input logic p, input logic c, input int n,
                       input logic [1:0] pos, input logic oc, input logic fm, input logic [3:0] db);
        vec_t v;
        v.ini = i; v.par = p; v.con = c; v.n = n;
        v.pos = pos; v.oc = oc; v.fm = fm; v.db = db;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] pos, input logic oc,
                         input logic fm, input logic [3:0] db);
        checks++;
        if ({posicao, ocupado, fim, db_estado} !== {pos, oc, fm, db}) begin
            errors++;
            $display("FAIL %s: got pos=%b oc=%b fim=%b db=%b, expected pos=%b oc=%b fim=%b db=%b",
                     name, posicao, ocupado, fim, db_estado, pos, oc, fm, db);
        end
    endtask

    task automatic cyc(input logic i, input logic p, input logic c);
        iniciar  = i;
        parar    = p;
        continuo = c;
        @(posedge clock);
        #1;
    endtask

    // Reference model: sweep as a list of positions, each held DWELL cycles.
    int seq[7] = '{0, 1, 2, 3, 2, 1, 0};
    int m_mode = 0;   // 0 idle, 1 sweeping, 2 finished pulse
    int m_idx  = 0;
    int m_t    = 0;

    task automatic model_step(input logic i, input logic p, input logic c);
        case (m_mode)
            0: if (i && !p) begin m_mode = 1; m_idx = 0; m_t = 0; end
            1: begin
                if (p) begin
                    m_mode = 0;
                end else begin
                    m_t++;
                    if (m_t == DWELL) begin
                        m_t = 0;
                        m_idx++;
                        if (m_idx == 7) begin
                            if (c) m_idx = 1;
                            else m_mode = 2;
                        end
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    initial begin
        // 1: reset held with iniciar high
        reset = 1'b0;
        iniciar = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold", 2'b00, 1'b0, 1'b0, 4'b0000);
        iniciar = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("after_release", 2'b00, 1'b0, 1'b0, 4'b0000);

        // 2: single sweep
        add(1,0,0,1,0,1,0,1); add(0,0,0,3,0,1,0,1);
        add(0,0,0,4,1,1,0,1); add(0,0,0,4,2,1,0,1); add(0,0,0,4,3,1,0,1);
        add(0,0,0,4,2,1,0,1); add(0,0,0,4,1,1,0,1); add(0,0,0,4,0,1,0,1);
        add(0,0,0,1,0,0,1,2); add(0,0,0,2,0,0,0,0);
        // 3: continuous, then dropped mid-sweep
        add(1,0,1,1,0,1,0,1); add(0,0,1,3,0,1,0,1);
        add(0,0,1,4,1,1,0,1); add(0,0,1,4,2,1,0,1); add(0,0,1,4,3,1,0,1);
        add(0,0,1,4,2,1,0,1); add(0,0,1,4,1,1,0,1); add(0,0,1,4,0,1,0,1);
        add(0,0,1,4,1,1,0,1); add(0,0,1,4,2,1,0,1);
        add(0,0,0,4,3,1,0,1); add(0,0,0,4,2,1,0,1); add(0,0,0,4,1,1,0,1);
        add(0,0,0,4,0,1,0,1); add(0,0,0,1,0,0,1,2); add(0,0,0,2,0,0,0,0);
        // 4a: abort while at 11
        add(1,0,0,1,0,1,0,1); add(0,0,0,3,0,1,0,1);
        add(0,0,0,4,1,1,0,1); add(0,0,0,4,2,1,0,1); add(0,0,0,2,3,1,0,1);
        add(0,1,0,1,0,0,0,0); add(0,0,0,3,0,0,0,0);
        // 4b: abort exactly at a terminal count
        add(1,0,0,1,0,1,0,1); add(0,0,0,3,0,1,0,1);
        add(0,1,0,1,0,0,0,0); add(0,0,0,2,0,0,0,0);
        // 5a: iniciar and parar together in idle
        add(1,1,0,3,0,0,0,0); add(0,0,0,1,0,0,0,0);
        // 5b: iniciar held through FINAL restarts after one idle cycle
        add(1,0,0,1,0,1,0,1); add(1,0,0,3,0,1,0,1);
        add(1,0,0,4,1,1,0,1); add(1,0,0,4,2,1,0,1); add(1,0,0,4,3,1,0,1);
        add(1,0,0,4,2,1,0,1); add(1,0,0,4,1,1,0,1); add(1,0,0,4,0,1,0,1);
        add(1,0,0,1,0,0,1,2); add(1,0,0,1,0,0,0,0); add(1,0,0,1,0,1,0,1);
        add(0,0,0,3,0,1,0,1); add(0,1,0,1,0,0,0,0); add(0,0,0,1,0,0,0,0);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                cyc(tbl[r].ini, tbl[r].par, tbl[r].con);
                check($sformatf("vec%0d.%0d", r, k), tbl[r].pos, tbl[r].oc, tbl[r].fm, tbl[r].db);
            end
        end

        // 6: async reset between edges mid-sweep
        cyc(1'b1, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        check("pre_async", 2'b10, 1'b1, 1'b0, 4'b0001);
        #2 reset = 1'b0;
        #1;
        check("async_reset", 2'b00, 1'b0, 1'b0, 4'b0000);
        @(posedge clock);
        #1;
        check("async_reset_hold", 2'b00, 1'b0, 1'b0, 4'b0000);
        reset = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check("async_release", 2'b00, 1'b0, 1'b0, 4'b0000);

        // randomized run against the reference model
        m_mode = 0; m_idx = 0; m_t = 0;
        for (int n = 0; n < 1500; n++) begin
            logic       ri, rp, rc;
            logic [1:0] e_pos;
            logic [3:0] e_db;
            ri = ($urandom_range(0, 3) == 0);
            rp = ($urandom_range(0, 39) == 0);
            rc = ($urandom_range(0, 2) != 0);
            model_step(ri, rp, rc);
            e_pos = (m_mode == 1) ? 2'(seq[m_idx]) : 2'b00;
            e_db  = (m_mode == 0) ? 4'b0000 : (m_mode == 1) ? 4'b0001 : 4'b0010;
            cyc(ri, rp, rc);
            check($sformatf("rand%0d", n), e_pos, (m_mode == 1), (m_mode == 2), e_db);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
